// File: rtl/vmem_writer.sv
// Write-side master for the video memory: STREAM fills the frame from a pixel stream, FILL paints a clipped rectangle.
// Latency: a write appears on mem_* one cycle after its pixel is accepted (STREAM) or generated (FILL); done lasts one cycle.
// Backpressure: cmd_ready only in IDLE, pix_ready only in STREAM; the memory side never stalls.
module vmem_writer #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [15:0] cmd_x0,
  input  logic [15:0] cmd_y0,
  input  logic [15:0] cmd_w,
  input  logic [15:0] cmd_h,
  input  logic [7:0]  cmd_color,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wren,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] HRES32 = 32'(H_RES);
  localparam logic [16:0] HRES17 = 17'(H_RES);
  localparam logic [16:0] VRES17 = 17'(V_RES);
  localparam logic [15:0] XLAST  = 16'(H_RES - 1);
  localparam logic [15:0] YLAST  = 16'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FILL, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] x, x_n, y, y_n, x0, x0_n;
  logic [16:0] xe, xe_n, ye, ye_n;
  logic [7:0]  color, color_n;
  logic [31:0] row_base, row_n;
  logic        wren_d;
  logic [31:0] addr_d, data_d;

  // Clipping uses 17-bit sums so 16'hFFFF operands cannot wrap past the frame edge.
  logic [16:0] x_sum, y_sum, xe_c, ye_c, x_inc, y_inc;
  logic        fill_empty;
  logic [31:0] pix_addr;

  assign x_sum      = {1'b0, cmd_x0} + {1'b0, cmd_w};
  assign y_sum      = {1'b0, cmd_y0} + {1'b0, cmd_h};
  assign xe_c       = (x_sum > HRES17) ? HRES17 : x_sum;
  assign ye_c       = (y_sum > VRES17) ? VRES17 : y_sum;
  assign fill_empty = (cmd_w == 16'd0) || (cmd_h == 16'd0) ||
                      ({1'b0, cmd_x0} >= HRES17) || ({1'b0, cmd_y0} >= VRES17);
  assign x_inc      = {1'b0, x} + 17'd1;
  assign y_inc      = {1'b0, y} + 17'd1;
  assign pix_addr   = row_base + 32'(x);

  // cmd_ready is held low while reset is asserted and rises once it is released.
  assign cmd_ready = (state == IDLE) && reset;
  assign pix_ready = (state == STREAM);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, walker advance and the write to be registered onto mem_*.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    x0_n    = x0;
    xe_n    = xe;
    ye_n    = ye;
    color_n = color;
    row_n   = row_base;
    wren_d  = 1'b0;
    addr_d  = mem_addr;
    data_d  = mem_data;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (!cmd_op) begin
            state_n = STREAM;
            x_n     = 16'd0;
            y_n     = 16'd0;
            row_n   = BASE_ADDR;
          end else begin
            x0_n    = cmd_x0;
            xe_n    = xe_c;
            ye_n    = ye_c;
            color_n = cmd_color;
            x_n     = cmd_x0;
            y_n     = cmd_y0;
            // Constant-coefficient product seeds the row accumulator once per command.
            row_n   = BASE_ADDR + 32'(cmd_y0) * HRES32;
            state_n = fill_empty ? DONE : FILL;
          end
        end
      end
      STREAM: begin
        if (pix_valid) begin
          wren_d = 1'b1;
          addr_d = pix_addr;
          data_d = {24'd0, pix_data};
          if (x == XLAST) begin
            x_n   = 16'd0;
            y_n   = y + 16'd1;
            row_n = row_base + HRES32;
            if (y == YLAST) state_n = DONE;
          end else begin
            x_n = x + 16'd1;
          end
        end
      end
      FILL: begin
        wren_d = 1'b1;
        addr_d = pix_addr;
        data_d = {24'd0, color};
        if (x_inc == xe) begin
          x_n   = x0;
          y_n   = y + 16'd1;
          row_n = row_base + HRES32;
          if (y_inc == ye) state_n = DONE;
        end else begin
          x_n = x + 16'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Walker registers and the registered memory port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x        <= 16'd0;
      y        <= 16'd0;
      x0       <= 16'd0;
      xe       <= 17'd0;
      ye       <= 17'd0;
      color    <= 8'd0;
      row_base <= 32'd0;
      mem_wren <= 1'b0;
      mem_addr <= 32'd0;
      mem_data <= 32'd0;
    end else begin
      x        <= x_n;
      y        <= y_n;
      x0       <= x0_n;
      xe       <= xe_n;
      ye       <= ye_n;
      color    <= color_n;
      row_base <= row_n;
      mem_wren <= wren_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
    end
  end

endmodule

// File: tb/tb_vmem_writer.sv
// Directed bench for vmem_writer: reset, full-frame STREAM, FILL with clipping, empty FILLs, busy handshake, reset mid-FILL.
// Writes and done pulses are captured on the falling edge; inputs are driven 1 time unit after the rising edge.
// Expected addresses and data are hand-computed for the default 320x240 frame at base address 0.
module tb_vmem_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [15:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;

  vmem_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          dq[$];
  int          done_n = 0;
  int          acc_cyc = 0;
  int          rdy_busy_err = 0;
  logic        mon_stream = 1'b0;
  logic        acc_q = 1'b0;
  int          stream_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Capture every write and done pulse; in stream mode each write must follow an accepted pixel.
  always @(negedge clk) begin
    if (mem_wren) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
    if (done) begin
      done_n++;
      dq.push_back(cyc);
    end
    if (mon_stream && (mem_wren !== acc_q)) stream_err++;
    acc_q = pix_valid & pix_ready;
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); dq.delete();
  endtask

  task automatic send_cmd(input logic op, input logic [15:0] x0, input logic [15:0] y0,
                          input logic [15:0] w, input logic [15:0] h, input logic [7:0] col);
    int n;
    cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = col;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      if (busy !== 1'b1) rdy_busy_err++;
      n++;
      @(negedge clk);
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_n <= start && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", done_n, start + 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, nw;
    logic [31:0] exp_a[6];
    // Reset state
    #2;
    check("rst_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pixrdy", {31'd0, pix_ready}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_data", mem_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    check("rel_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // FILL 10,5 3x2 colour A5: rows start at 5*320+10 and 6*320+10
    exp_a = '{32'd1610, 32'd1611, 32'd1612, 32'd1930, 32'd1931, 32'd1932};
    clear_log(); d0 = done_n;
    send_cmd(1'b1, 16'd10, 16'd5, 16'd3, 16'd2, 8'hA5);
    wait_done(d0);
    check("fill_cnt", wa.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fill_addr%0d", i), (i < wa.size()) ? wa[i] : 32'hFFFFFFFF, exp_a[i]);
      check($sformatf("fill_data%0d", i), (i < wd.size()) ? wd[i] : 32'hFFFFFFFF, 32'h000000A5);
      check($sformatf("fill_cyc%0d", i), (i < wc.size()) ? wc[i] : -1, (wc.size() > 0) ? wc[0] + i : -2);
    end
    check("fill_last_in_done", (wc.size() > 0) ? wc[wc.size()-1] : -1, (dq.size() > 0) ? dq[0] : -2);

    // Clipped FILL at the bottom-right corner
    clear_log(); d0 = done_n;
    send_cmd(1'b1, 16'd318, 16'd239, 16'd10, 16'd10, 8'h11);
    wait_done(d0);
    check("clip_cnt", wa.size(), 32'd2);
    check("clip_a0", (wa.size() > 0) ? wa[0] : 32'hFFFFFFFF, 32'd76798);
    check("clip_a1", (wa.size() > 1) ? wa[1] : 32'hFFFFFFFF, 32'd76799);

    // FILL with 16'hFFFF sizes is clipped to the frame
    clear_log(); d0 = done_n;
    send_cmd(1'b1, 16'd319, 16'd238, 16'hFFFF, 16'hFFFF, 8'h22);
    wait_done(d0);
    check("ovf_cnt", wa.size(), 32'd2);
    check("ovf_a1", (wa.size() > 1) ? wa[1] : 32'hFFFFFFFF, 32'd76799);

    // Empty FILLs: done is visible in the cycle right after the accepting edge
    clear_log(); d0 = done_n;
    send_cmd(1'b1, 16'd10, 16'd10, 16'd0, 16'd5, 8'h33);
    wait_done(d0);
    check("empty_w_cnt", wa.size(), 32'd0);
    check("empty_w_done", (dq.size() > 0) ? dq[0] : -1, acc_cyc);
    clear_log(); d0 = done_n;
    send_cmd(1'b1, 16'd400, 16'd10, 16'd5, 16'd5, 8'h33);
    wait_done(d0);
    check("empty_x_cnt", wa.size(), 32'd0);
    check("empty_x_done", (dq.size() > 0) ? dq[0] : -1, acc_cyc);
    check("empty_done_pulses", dq.size(), 32'd1);

    // Command offered while busy: held off, then taken in the IDLE cycle after DONE
    clear_log(); d0 = done_n; rdy_busy_err = 0;
    send_cmd(1'b1, 16'd0, 16'd0, 16'd20, 16'd3, 8'h44);
    send_cmd(1'b1, 16'd100, 16'd100, 16'd2, 16'd1, 8'h3C);
    wait_done(d0 + 1);
    check("busy_rdy_low", rdy_busy_err, 32'd0);
    check("busy_accept_cyc", acc_cyc, (dq.size() > 0) ? dq[0] + 2 : -1);
    check("busy_cnt", wa.size(), 32'd62);
    check("busy_a60", (wa.size() > 60) ? wa[60] : 32'hFFFFFFFF, 32'd32100);
    check("busy_d61", (wd.size() > 61) ? wd[61] : 32'hFFFFFFFF, 32'h3C);

    // Full-frame STREAM, pix_valid toggling for the first 2048 pixels
    clear_log(); d0 = done_n; stream_err = 0;
    send_cmd(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0);
    mon_stream = 1'b1;
    for (int i = 0; i < 76800; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(i);
      @(posedge clk); #1;
      if (i < 2048) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 mon_stream = 1'b0;
    check("stream_cnt", wa.size(), 32'd76800);
    nw = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 32'(i) || wd[i] !== {24'd0, 8'(i)}) nw++;
    check("stream_addr_data", nw, 32'd0);
    check("stream_timing", stream_err, 32'd0);
    check("stream_done", done_n - d0, 32'd1);
    check("stream_done_last", (dq.size() > 0) ? dq[0] : -1, (wc.size() > 0) ? wc[wc.size()-1] : -2);

    // Reset in the middle of a FILL
    clear_log();
    send_cmd(1'b1, 16'd0, 16'd0, 16'd100, 16'd10, 8'h55);
    repeat (20) @(posedge clk);
    #1;
    check("mid_wren_before", {31'd0, mem_wren}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_wren_async", {31'd0, mem_wren}, 32'd0);
    check("mid_busy_async", {31'd0, busy}, 32'd0);
    nw = wa.size();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_no_more_writes", wa.size(), nw);
    check("mid_last_addr", (wa.size() > 0) ? wa[wa.size()-1] : 32'hFFFFFFFF, 32'(nw - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
